// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared sizes and loader state encoding for the MVM input path
package mvm_pkg;

    localparam int MAT_SCALE   = 4;
    localparam int INPUT_WIDTH = 8;
    localparam int FRAME_LEN   = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    localparam int CNT_W       = $clog2(FRAME_LEN + 1);

    typedef enum logic [2:0] {
        FILL,
        START,
        BURST,
        WAIT_DONE,
        DRAIN
    } loader_state_t;

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - one frame of elements, single write port, registered read
module frame_buffer
    import mvm_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr_en,
    input  logic [CNT_W-1:0]       i_wr_addr,
    input  logic [INPUT_WIDTH-1:0] i_wr_data,
    input  logic                   i_rd_en,
    input  logic [CNT_W-1:0]       i_rd_addr,
    output logic [INPUT_WIDTH-1:0] o_rd_data
);

    logic [INPUT_WIDTH-1:0] r_mem [FRAME_LEN];
    logic [INPUT_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register holds its value when not read, so it doubles as the held output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mvm_input_loader.sv
// rtl/mvm_input_loader.sv - buffers a frame and bursts it to the MVM core; MVM_LOADER_PINGPONG_EN adds a second bank
module mvm_input_loader
    import mvm_pkg::*;
#(
    parameter int DRAIN_CYCLES = MAT_SCALE + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   start,
    output logic [INPUT_WIDTH-1:0] data_out,
    input  logic                   done,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    loader_state_t    r_state;
    loader_state_t    w_state_next;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_next;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_drain_cnt_next;
    logic             w_accept;
    logic             w_frame_full;
    logic             w_other_full;
    logic             w_drain_exit;
    logic             w_rd_en;
    logic [CNT_W-1:0] w_rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FILL;
            r_burst_cnt <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // Reads run one cycle ahead of data_out: START fetches element 0, BURST count c fetches c+1.
    always_comb begin
        w_state_next     = r_state;
        w_burst_cnt_next = r_burst_cnt;
        w_drain_cnt_next = r_drain_cnt;
        w_rd_en          = 1'b0;
        w_rd_addr        = '0;
        w_drain_exit     = 1'b0;
        case (r_state)
            FILL: begin
                if (w_frame_full) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_burst_cnt_next = '0;
                w_rd_en          = 1'b1;
                w_rd_addr        = '0;
                w_state_next     = BURST;
            end
            BURST: begin
                w_burst_cnt_next = r_burst_cnt + CNT_ONE;
                if (r_burst_cnt < LAST_IDX) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_burst_cnt + CNT_ONE;
                end else begin
                    w_state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    w_drain_cnt_next = DRAIN_LOAD;
                    w_state_next     = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_drain_exit = 1'b1;
                    w_state_next = w_other_full ? START : FILL;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    assign start = (r_state == START) && !reset;
    assign busy  = (r_state != FILL);

`ifdef MVM_LOADER_PINGPONG_EN
    logic                   r_bank;
    logic                   r_out_bank;
    logic                   w_fill_bank;
    logic [CNT_W-1:0]       r_fill_cnt [2];
    logic [INPUT_WIDTH-1:0] w_rd_data  [2];

    // r_bank is the bank being (or about to be) burst; outside FILL the other bank takes input.
    assign w_fill_bank  = (r_state == FILL) ? r_bank : !r_bank;
    assign in_ready     = !reset && (r_fill_cnt[w_fill_bank] < FULL_CNT);
    assign w_accept     = in_valid && in_ready;
    assign w_frame_full = (r_fill_cnt[w_fill_bank] + CNT_W'(w_accept)) == FULL_CNT;
    assign w_other_full = w_frame_full;
    assign data_out     = w_rd_data[r_out_bank];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank        <= 1'b0;
            r_out_bank    <= 1'b0;
            r_fill_cnt[0] <= '0;
            r_fill_cnt[1] <= '0;
        end else begin
            if (w_drain_exit) begin
                r_bank <= !r_bank;
            end
            // Output mux follows the new bank only once its first element is in the read register.
            if (r_state == START) begin
                r_out_bank <= r_bank;
            end
            for (int b = 0; b < 2; b++) begin
                if (w_drain_exit && (r_bank == 1'(b))) begin
                    r_fill_cnt[b] <= '0;
                end else if (w_accept && (w_fill_bank == 1'(b))) begin
                    r_fill_cnt[b] <= r_fill_cnt[b] + CNT_ONE;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_buffer u_frame_buffer (
            .clk       (clk),
            .reset     (reset),
            .i_wr_en   (w_accept && (w_fill_bank == 1'(b))),
            .i_wr_addr (r_fill_cnt[b]),
            .i_wr_data (in_data),
            .i_rd_en   (w_rd_en && (r_bank == 1'(b))),
            .i_rd_addr (w_rd_addr),
            .o_rd_data (w_rd_data[b])
        );
    end
`else
    logic [CNT_W-1:0] r_fill_cnt;

    assign in_ready     = !reset && (r_state == FILL) && (r_fill_cnt < FULL_CNT);
    assign w_accept     = in_valid && in_ready;
    assign w_frame_full = (r_fill_cnt + CNT_W'(w_accept)) == FULL_CNT;
    assign w_other_full = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill_cnt <= '0;
        end else if (w_drain_exit) begin
            r_fill_cnt <= '0;
        end else if (w_accept) begin
            r_fill_cnt <= r_fill_cnt + CNT_ONE;
        end
    end

    frame_buffer u_frame_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_fill_cnt),
        .i_wr_data (in_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (data_out)
    );
`endif

endmodule

// File: tb/tb_mvm_input_loader.sv
// tb/tb_mvm_input_loader.sv - scoreboard bench for mvm_input_loader
module tb_mvm_input_loader;

    localparam int FL    = 20;
    localparam int DRAIN = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       start;
    logic [7:0] data_out;
    logic       done;
    logic       done_resp;
    logic       done_stray;
    logic       busy;

    assign done = done_resp | done_stray;

    always #5 clk = ~clk;

    mvm_input_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .start    (start),
        .data_out (data_out),
        .done     (done),
        .busy     (busy)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         burst_end_cnt = 0;
    int         mon_k = 0;
    int         done_delay = 2;
    bit         in_burst = 0;
    bit         hold_chk = 0;
    bit         resp_active = 0;
    bit         pp_expect_direct = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_fill[$];
    int         exp_start_q[$];
    logic [7:0] frame_vals[FL];
    logic [7:0] last_val;
    logic [7:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Reference model: accepted elements collect into a frame; a complete frame becomes the expected burst.
    task automatic send_elems(input int from, input int to, input int valid_pct);
        for (int i = from; i < to; i++) begin
            int waited = 0;
            bit sent = 0;
            while (!sent) begin
                in_data  = frame_vals[i];
                in_valid = (int'($urandom_range(99)) < valid_pct);
                if (in_valid && in_ready) begin
                    sent = 1;
                    model_fill.push_back(frame_vals[i]);
                    if (model_fill.size() == FL) begin
                        foreach (model_fill[j]) exp_q.push_back(model_fill[j]);
                        exp_start_q.push_back(busy ? -1 : cyc + 1);
                        model_fill.delete();
                    end
                end else if (++waited > 2000) begin
                    check("accept_timeout", waited, 2000);
                    in_valid = 1'b0;
                    return;
                end
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int t = 0;
        while (!(exp_q.size() == 0 && busy == 1'b0 && !resp_active && !in_burst && !hold_chk)) begin
            step();
            if (++t > 2000) begin
                check("idle_timeout", t, 2000);
                return;
            end
        end
        check("idle_in_ready", in_ready, 1);
    endtask

    // Monitor: pops expected elements whenever a burst is running.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_burst = 0;
                hold_chk = 0;
                mon_k    = 0;
                exp_q.delete();
                exp_start_q.delete();
            end else begin
                if (hold_chk) begin
                    check("hold_last", data_out, last_val);
                    hold_chk = 0;
                    burst_end_cnt++;
                end
                if (in_burst) begin
                    if (exp_q.size() == 0) begin
                        check("burst_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("burst_data", data_out, e);
                    end
                    check("burst_start_low", start, 0);
                    check("burst_busy", busy, 1);
`ifndef MVM_LOADER_PINGPONG_EN
                    check("burst_in_ready", in_ready, 0);
`endif
                    mon_k++;
                    if (mon_k == FL) begin
                        in_burst = 0;
                        hold_chk = 1;
                        last_val = e;
                    end
                end else if (start) begin
                    if (exp_start_q.size() == 0) begin
                        check("start_without_frame", exp_start_q.size(), 1);
                    end else begin
                        int s;
                        s = exp_start_q.pop_front();
                        if (s >= 0) check("start_latency", cyc, s);
                    end
                    check("start_busy", busy, 1);
                    in_burst = 1;
                    mon_k    = 0;
                end
            end
        end
    end

    // Core model: answers each completed burst with done after done_delay cycles.
    initial begin
        int handled = 0;
        int n;
        done_resp = 1'b0;
        forever begin
            step();
            if (burst_end_cnt != handled) begin
                handled     = burst_end_cnt;
                resp_active = 1;
                for (int d = 0; d < done_delay; d++) begin
                    step();
                    check("wait_done_busy", busy, 1);
                end
                done_resp = 1'b1;
                step();
                done_resp = 1'b0;
                n = 1;
                while (n < 60) begin
                    if (busy == 1'b0 || start == 1'b1) break;
                    @(negedge clk);
                    n++;
                end
                check("drain_exit_cycle", n, DRAIN + 1);
`ifdef MVM_LOADER_PINGPONG_EN
                if (pp_expect_direct) begin
                    check("pp_direct_start", start, 1);
                    pp_expect_direct = 0;
                end
`endif
                resp_active = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        done_stray = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < FL; i++) frame_vals[i] = 8'(i + 1);
        done_delay = 2;
        send_elems(0, FL, 100);
        wait_idle();

        done_delay = 5;
        send_elems(0, FL, 50);
        wait_idle();

        for (int i = 0; i < FL; i++) frame_vals[i] = 8'($urandom);
        done_delay = 30;
        send_elems(0, FL, 70);
        wait_idle();

        for (int i = 0; i < FL; i++) frame_vals[i] = 8'($urandom);
        done_delay = 3;
        send_elems(0, FL, 100);
        t = 0;
        while (!(in_burst && mon_k == 8)) begin
            step();
            if (++t > 500) begin
                check("burst_k_timeout", t, 500);
                break;
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_fill.delete();
        step();
        check("midrst_start", start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_in_ready", in_ready, 1);

        for (int i = 0; i < FL; i++) frame_vals[i] = 8'(-128 + i);
        done_delay = 1;
        send_elems(0, FL, 100);
        wait_idle();

        done_stray = 1'b1;
        step();
        done_stray = 1'b0;
        step();
        check("stray_busy", busy, 0);
        check("stray_in_ready", in_ready, 1);
        for (int i = 0; i < FL; i++) frame_vals[i] = 8'($urandom);
        send_elems(0, FL / 2, 60);
        for (int i = 0; i < 15; i++) begin
            done_stray = (i == 7);
            step();
        end
        done_stray = 1'b0;
        check("partial_no_start", busy, 0);
        check("partial_in_ready", in_ready, 1);
        send_elems(FL / 2, FL, 60);
        wait_idle();

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FL; i++) frame_vals[i] = 8'($urandom);
            done_delay = int'($urandom_range(10));
            send_elems(0, FL, int'($urandom_range(30, 100)));
            wait_idle();
        end

`ifdef MVM_LOADER_PINGPONG_EN
        pp_expect_direct = 1;
        done_delay = 3;
        for (int i = 0; i < FL; i++) frame_vals[i] = 8'(100 + i);
        send_elems(0, FL, 100);
        for (int i = 0; i < FL; i++) frame_vals[i] = 8'(200 + i);
        send_elems(0, FL, 100);
        wait_idle();
        check("pp_direct_consumed", pp_expect_direct, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
